// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard event path: event field layout helpers
// and the scan FSM state type.
package kbd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // The break flag always sits in the MSB of an event; the key code fills the rest.
  function automatic int event_break_bit(input int event_w);
    return event_w - 1;
  endfunction

  function automatic logic [31:0] pack_event(input logic        brk,
                                             input logic [31:0] code,
                                             input int          event_w);
    logic [31:0] ev;
    ev = code;
    ev[event_break_bit(event_w)] = brk;
    return ev;
  endfunction

  function automatic logic event_is_break(input logic [31:0] ev, input int event_w);
    return ev[event_break_bit(event_w)];
  endfunction

  function automatic logic [31:0] event_code(input logic [31:0] ev, input int event_w);
    return ev & ((32'd1 << event_break_bit(event_w)) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until the level says so.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/key_event_queue.sv
// Walks a snapshot of the key bitmap one key per cycle, debounces each key
// across scans and queues make/break events for the UART side.
module key_event_queue
  import kbd_pkg::*;
#(
  parameter int NUM_KEYS       = 104,
  parameter int EVENT_W        = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          enable,
  input  logic                          row_sync,
  input  logic [NUM_KEYS-1:0]           key_down,
  output logic [EVENT_W-1:0]            ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          scan_busy
);

  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_KEYS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);

  scan_state_e         state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [NUM_KEYS-1:0] reported_q, reported_d;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d, cur_cnt, cnt_inc;
  logic                cur_snap, cur_rep;
  logic                overflow_q, overflow_d, overflow_set;
  logic                push, pop, push_ok;
  logic                fifo_full, fifo_empty;
  logic [EVENT_W-1:0]  push_data, fifo_dout;

  assign cur_snap  = snap_q[idx_q];
  assign cur_rep   = reported_q[idx_q];
  assign cur_cnt   = cnt_q[idx_q];
  assign cnt_inc   = (cur_cnt == CNT_MAX) ? CNT_MAX : cur_cnt + CW'(1);
  assign push_data = EVENT_W'(pack_event(~cur_snap, 32'(idx_q), EVENT_W));

  assign pop        = ~fifo_empty & ev_ready;
  assign push_ok    = ~fifo_full | pop;
  assign ev_valid   = ~fifo_empty;
  assign ev_data    = fifo_empty ? '0 : fifo_dout;
  assign overflow   = overflow_q;
  assign scan_busy  = (state_q == SCAN);

  // A rejected push leaves the counter saturated so the key retries next scan.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    reported_d   = reported_q;
    cnt_d        = cur_cnt;
    push         = 1'b0;
    overflow_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (row_sync && enable) begin
          state_d = SCAN;
          idx_d   = '0;
          snap_d  = key_down;
        end
      end
      SCAN: begin
        if (cur_snap == cur_rep) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            push = 1'b1;
            if (push_ok) begin
              reported_d[idx_q] = cur_snap;
              cnt_d             = '0;
            end else begin
              overflow_set = 1'b1;
            end
          end
        end
        if (idx_q == LAST_IDX) state_d = IDLE;
        else                   idx_d   = idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
    overflow_d = (overflow_q & ~overflow_clr) | overflow_set;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      reported_q <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      reported_q <= reported_d;
      overflow_q <= overflow_d;
      if (state_q == SCAN) cnt_q[idx_q] <= cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus randomized scans, all
// compared cycle by cycle against a queue-based reference model.
module tb_key_event_queue;

  localparam int NK = 104;
  localparam int EW = 8;
  localparam int FD = 16;
  localparam int DB = 2;
  localparam int LW = $clog2(FD) + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          enable;
  logic          row_sync;
  logic [NK-1:0] key_down;
  logic [EW-1:0] ev_data;
  logic          ev_valid;
  logic          ev_ready;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          overflow_clr;
  logic          scan_busy;

  always #10 sys_clk = ~sys_clk;

  key_event_queue #(
    .NUM_KEYS       (NK),
    .EVENT_W        (EW),
    .FIFO_DEPTH     (FD),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .enable       (enable),
    .row_sync     (row_sync),
    .key_down     (key_down),
    .ev_data      (ev_data),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .scan_busy    (scan_busy)
  );

  // Reference model: per-key reported state and consecutive-differing-scan
  // count, plus the event queue itself.
  bit [NK-1:0]   mRep;
  int            mCnt [NK];
  bit [NK-1:0]   mSnap;
  bit            mScan;
  int            mPos;
  bit            mOvf;
  logic [EW-1:0] mQ [$];
  logic [EW-1:0] gotQ [$];
  logic [NK-1:0] held;

  int checks = 0;
  int errors = 0;
  int busyCnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NK-1:0] keyRange(input int lo, input int hi);
    logic [NK-1:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic modelStep();
    bit            popNow, pushNow, ovfSet;
    logic [EW-1:0] ev;
    int            k;
    if (!sys_rst_n) begin
      mRep = '0; mSnap = '0; mScan = 0; mPos = 0; mOvf = 0;
      for (int i = 0; i < NK; i++) mCnt[i] = 0;
      mQ.delete();
      return;
    end
    popNow  = (mQ.size() > 0) && ev_ready;
    pushNow = 0;
    ovfSet  = 0;
    ev      = '0;
    if (mScan) begin
      k = mPos;
      if (mSnap[k] != mRep[k]) begin
        if (mCnt[k] < DB) mCnt[k]++;
        if (mCnt[k] == DB) begin
          if (mQ.size() < FD || popNow) begin
            pushNow = 1;
            ev = EW'(k);
            ev[EW-1] = ~mSnap[k];
            mRep[k] = mSnap[k];
            mCnt[k] = 0;
          end else begin
            ovfSet = 1;
          end
        end
      end else begin
        mCnt[k] = 0;
      end
      mPos++;
      if (mPos == NK) mScan = 0;
    end else if (row_sync && enable) begin
      mSnap = key_down;
      mScan = 1;
      mPos  = 0;
    end
    if (popNow) void'(mQ.pop_front());
    if (pushNow) mQ.push_back(ev);
    if (overflow_clr) mOvf = 0;
    if (ovfSet) mOvf = 1;
  endtask

  task automatic applyStimulus();
    if (ev_valid && ev_ready && sys_rst_n) gotQ.push_back(ev_data);
    modelStep();
    @(posedge sys_clk);
    #1;
    checkOutput("ev_valid", ev_valid, mQ.size() != 0);
    checkOutput("ev_data", ev_data, (mQ.size() != 0) ? mQ[0] : '0);
    checkOutput("fifo_level", fifo_level, mQ.size());
    checkOutput("overflow", overflow, mOvf);
    checkOutput("scan_busy", scan_busy, mScan);
    row_sync     = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic scanOnce(input logic [NK-1:0] keys);
    key_down = keys;
    enable   = 1'b1;
    row_sync = 1'b1;
    applyStimulus();
    repeat (NK + 2) applyStimulus();
  endtask

  task automatic resetDut();
    sys_rst_n = 1'b0;
    repeat (2) applyStimulus();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0; enable = 1'b0; row_sync = 1'b0; key_down = '0;
    ev_ready = 1'b1; overflow_clr = 1'b0; held = '0;

    $display("[TB] reset state");
    resetDut();
    checkOutput("rst_valid", ev_valid, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_busy", scan_busy, 0);
    checkOutput("rst_ovf", overflow, 0);

    $display("[TB] press and release key 5");
    gotQ.delete();
    scanOnce(keyRange(5, 5));
    checkOutput("one_scan_no_event", gotQ.size(), 0);
    scanOnce(keyRange(5, 5));
    checkOutput("make_count", gotQ.size(), 1);
    if (gotQ.size() >= 1) checkOutput("make_code", gotQ[0], 8'h05);
    scanOnce('0);
    scanOnce('0);
    checkOutput("break_count", gotQ.size(), 2);
    if (gotQ.size() >= 2) checkOutput("break_code", gotQ[1], 8'h85);

    $display("[TB] single-scan glitches on key 5");
    gotQ.delete();
    scanOnce(keyRange(5, 5));
    scanOnce('0);
    scanOnce(keyRange(5, 5));
    scanOnce('0);
    checkOutput("glitch_no_event", gotQ.size(), 0);

    $display("[TB] overflow with backpressure, then retry");
    ev_ready = 1'b0;
    held = keyRange(0, 19);
    scanOnce(held);
    scanOnce(held);
    checkOutput("full_level", fifo_level, 16);
    checkOutput("full_ovf", overflow, 1);
    ev_ready = 1'b1;
    gotQ.delete();
    repeat (20) applyStimulus();
    scanOnce(held);
    scanOnce(held);
    checkOutput("retry_count", gotQ.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < gotQ.size()) checkOutput("retry_order", gotQ[i], i);
    overflow_clr = 1'b1;
    applyStimulus();
    checkOutput("ovf_cleared", overflow, 0);

    $display("[TB] row_sync mid-scan and enable low");
    key_down = held; enable = 1'b1; row_sync = 1'b1;
    applyStimulus();
    busyCnt = scan_busy;
    for (int c = 1; c <= NK + 3; c++) begin
      if (c == 50) row_sync = 1'b1;
      applyStimulus();
      if (scan_busy) busyCnt++;
    end
    checkOutput("scan_length", busyCnt, NK);
    enable = 1'b0; row_sync = 1'b1;
    applyStimulus();
    checkOutput("enable_low_no_scan", scan_busy, 0);

    $display("[TB] push and pop together at full, clear vs set");
    resetDut();
    ev_ready = 1'b0;
    held = keyRange(0, 15);
    scanOnce(held);
    scanOnce(held);
    checkOutput("fill_level", fifo_level, 16);
    checkOutput("fill_no_ovf", overflow, 0);
    held[20] = 1'b1;
    scanOnce(held);
    gotQ.delete();
    key_down = held; enable = 1'b1; row_sync = 1'b1;
    applyStimulus();
    for (int j = 1; j <= NK + 2; j++) begin
      ev_ready = (j == 21);
      applyStimulus();
      if (j == 21) begin
        checkOutput("pushpop_full_level", fifo_level, 16);
        checkOutput("pushpop_full_ovf", overflow, 0);
      end
    end
    checkOutput("pushpop_pop_count", gotQ.size(), 1);
    if (gotQ.size() >= 1) checkOutput("pushpop_pop_head", gotQ[0], 8'h00);
    held[21] = 1'b1;
    scanOnce(held);
    key_down = held; enable = 1'b1; row_sync = 1'b1;
    applyStimulus();
    for (int j = 1; j <= NK + 2; j++) begin
      overflow_clr = (j == 22);
      applyStimulus();
      if (j == 22) checkOutput("ovf_set_wins", overflow, 1);
    end
    overflow_clr = 1'b1;
    applyStimulus();
    checkOutput("ovf_clear_alone", overflow, 0);

    $display("[TB] reset during scan");
    resetDut();
    ev_ready = 1'b0;
    held = keyRange(0, 4);
    scanOnce(held);
    scanOnce(held);
    checkOutput("five_queued", fifo_level, 5);
    key_down = held; enable = 1'b1; row_sync = 1'b1;
    applyStimulus();
    repeat (10) applyStimulus();
    sys_rst_n = 1'b0;
    applyStimulus();
    checkOutput("midreset_valid", ev_valid, 0);
    checkOutput("midreset_level", fifo_level, 0);
    checkOutput("midreset_busy", scan_busy, 0);
    sys_rst_n = 1'b1;
    ev_ready = 1'b1;
    gotQ.delete();
    scanOnce(held);
    checkOutput("rereport_wait", gotQ.size(), 0);
    scanOnce(held);
    checkOutput("rereport_count", gotQ.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < gotQ.size()) checkOutput("rereport_code", gotQ[i], i);

    $display("[TB] randomized scans");
    resetDut();
    held = '0;
    for (int s = 0; s < 30; s++) begin
      int readyPct;
      int gap;
      readyPct = $urandom_range(0, 3) * 33;
      gap = $urandom_range(0, 5);
      for (int i = 0; i < NK; i++)
        if ((i < 24 || i >= 96) && $urandom_range(0, 3) == 0) held[i] = ~held[i];
      key_down = held;
      enable   = ($urandom_range(0, 7) != 0);
      row_sync = 1'b1;
      ev_ready = ($urandom_range(0, 99) < readyPct);
      applyStimulus();
      for (int c = 0; c < NK + gap; c++) begin
        ev_ready     = ($urandom_range(0, 99) < readyPct);
        overflow_clr = ($urandom_range(0, 31) == 0);
        row_sync     = ($urandom_range(0, 63) == 0);
        enable       = ($urandom_range(0, 7) != 0);
        applyStimulus();
      end
    end
    ev_ready = 1'b1;
    repeat (FD + 2) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
